// File: rtl/synth_slot_sched_pkg.sv
// -----------------------------------------------------------------------------
// synth_slot_sched_pkg
// Shared types and constants for the synth frame scheduler.
//   sched_state_e   : scheduler FSM states (IDLE -> ARM -> RUN).
//   slot_w()        : width of the {voice, env} slot index.
//   DEF_ENV_DIV     : default AUDIO_CLK cycles per envelope slot, derived from
//                     the audio clock, the sample rate and the slot count.
// -----------------------------------------------------------------------------
package synth_slot_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } sched_state_e;

  localparam int AUDIO_CLK_RATE = 98_304_000;
  localparam int SAMPLE_RATE    = 48_000;
  localparam int DEF_VOICES     = 32;
  localparam int DEF_V_ENVS     = 8;

  // One full frame of VOICES*V_ENVS envelope slots per output sample.
  localparam int DEF_ENV_DIV = AUDIO_CLK_RATE / (SAMPLE_RATE * DEF_VOICES * DEF_V_ENVS);

  function automatic int slot_w(input int v_width, input int e_width);
    return v_width + e_width;
  endfunction

endpackage

// File: rtl/synth_slot_sched_if.sv
// -----------------------------------------------------------------------------
// synth_slot_sched_if
// Bundle between the frame scheduler and its surroundings.
//   trig        : frame request level (rising edge is the event)
//   free_run    : repeat frames back-to-back while high
//   env_ce      : one-cycle envelope-slot enable
//   osc_ce      : one-cycle oscillator-slot enable
//   xxxx        : slot index {voice, env}
//   xxxx_zero   : high while xxxx == 0
//   run         : frame in progress
//   frame_start : first cycle of each frame
//   frame_done  : cycle after the last slot of a frame
//   overrun     : sticky, a trig was lost
// master = trigger source / engine side, slave = scheduler.
// -----------------------------------------------------------------------------
interface synth_slot_sched_if #(
  parameter int V_WIDTH = 5,
  parameter int E_WIDTH = 3
);
  import synth_slot_sched_pkg::*;

  localparam int SW = slot_w(V_WIDTH, E_WIDTH);

  logic          trig;
  logic          free_run;
  logic          env_ce;
  logic          osc_ce;
  logic [SW-1:0] xxxx;
  logic          xxxx_zero;
  logic          run;
  logic          frame_start;
  logic          frame_done;
  logic          overrun;

  modport master (
    output trig, free_run,
    input  env_ce, osc_ce, xxxx, xxxx_zero, run, frame_start, frame_done, overrun
  );

  modport slave (
    input  trig, free_run,
    output env_ce, osc_ce, xxxx, xxxx_zero, run, frame_start, frame_done, overrun
  );

endinterface

// File: rtl/synth_slot_sched_div.sv
// -----------------------------------------------------------------------------
// synth_slot_div
// Envelope-slot divider: counts 0..ENV_DIV-1 while enabled and wraps.
// ce is registered and is high in exactly the cycle the count equals
// ENV_DIV-1, so it is decoded one count early.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear of count and ce
//   en       : count enable
//   ce       : one-cycle slot enable
// -----------------------------------------------------------------------------
module synth_slot_div
  import synth_slot_sched_pkg::*;
#(
  parameter int ENV_DIV = DEF_ENV_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic ce
);

  localparam int CW = (ENV_DIV < 2) ? 1 : $clog2(ENV_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(ENV_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(ENV_DIV - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ce  <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ce  <= 1'b0;
    end else if (en) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_ONE;
      ce  <= (cnt == CNT_PRE);
    end else begin
      ce  <= 1'b0;
    end
  end

endmodule

// File: rtl/synth_slot_sched.sv
// -----------------------------------------------------------------------------
// synth_slot_sched
// Frame scheduler for the time-multiplexed voice/envelope datapath. Produces
// single-clock enable strobes instead of divided clocks and owns the slot
// index and the frame sequencing.
//   AUDIO_CLK : sole clock, rising edge
//   reset_reg : asynchronous active-high reset
//   bus       : synth_slot_sched_if.slave (trig/free_run in, strobes,
//               slot index and frame status out)
// A trig rising edge (or free_run) arms a frame; the frame starts two cycles
// after the edge and lasts VOICES*V_ENVS*ENV_DIV cycles. Edges arriving while
// a frame runs are queued once in pending; a second queued edge sets overrun.
// -----------------------------------------------------------------------------
module synth_slot_sched
  import synth_slot_sched_pkg::*;
#(
  parameter int VOICES  = DEF_VOICES,
  parameter int V_ENVS  = DEF_V_ENVS,
  parameter int V_WIDTH = 5,
  parameter int E_WIDTH = 3,
  parameter int ENV_DIV = DEF_ENV_DIV
) (
  input  logic               AUDIO_CLK,
  input  logic               reset_reg,
  synth_slot_sched_if.slave  bus
);

  localparam int SW = slot_w(V_WIDTH, E_WIDTH);
  localparam logic [SW-1:0] SLOT_MAX = '1;
  localparam logic [SW-1:0] SLOT_ONE = SW'(1);

  if ((2 ** V_WIDTH) != VOICES) begin : g_chk_voices
    $error("synth_slot_sched: 2**V_WIDTH must equal VOICES");
  end
  if ((2 ** E_WIDTH) != V_ENVS) begin : g_chk_envs
    $error("synth_slot_sched: 2**E_WIDTH must equal V_ENVS");
  end
  if ((V_ENVS % 2) != 0) begin : g_chk_odd
    $error("synth_slot_sched: V_ENVS must be even");
  end
  if (ENV_DIV < 2) begin : g_chk_div
    $error("synth_slot_sched: ENV_DIV must be >= 2");
  end

  sched_state_e  state, state_nxt;
  logic          trig_dly;
  logic          trig_rise;
  logic          pending, pending_nxt;
  logic          overrun_r, overrun_nxt;
  logic [SW-1:0] slot, slot_nxt;
  logic          run_r;
  logic          frame_start_r, frame_start_nxt;
  logic          frame_done_r, frame_done_nxt;
  logic          xxxx_zero_r;
  logic          env_ce;
  logic          div_en;
  logic          div_clr;
  logic          wrap;

  assign trig_rise = bus.trig & ~trig_dly;
  assign div_en    = (state == RUN);
  assign div_clr   = (state != RUN);

  // The env_ce that takes the slot index from max back to 0 ends the frame.
  assign wrap = (state == RUN) & env_ce & (slot == SLOT_MAX);

  synth_slot_div #(
    .ENV_DIV (ENV_DIV)
  ) u_div (
    .clk (AUDIO_CLK),
    .rst (reset_reg),
    .clr (div_clr),
    .en  (div_en),
    .ce  (env_ce)
  );

  always_comb begin
    state_nxt       = state;
    pending_nxt     = pending;
    overrun_nxt     = overrun_r;
    slot_nxt        = slot;
    frame_start_nxt = 1'b0;
    frame_done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        slot_nxt    = '0;
        pending_nxt = 1'b0;
        if (trig_rise || bus.free_run) begin
          state_nxt = ARM;
        end
      end
      ARM: begin
        state_nxt       = RUN;
        frame_start_nxt = 1'b1;
      end
      RUN: begin
        if (env_ce) begin
          slot_nxt = slot + SLOT_ONE;
        end
        if (wrap) begin
          frame_done_nxt = 1'b1;
          if (bus.free_run || pending) begin
            // Queued request is consumed; an edge landing right now is
            // queued for the frame after.
            frame_start_nxt = 1'b1;
            pending_nxt     = trig_rise;
          end else if (trig_rise) begin
            frame_start_nxt = 1'b1;
            pending_nxt     = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (trig_rise && !frame_done_r) begin
          // An edge in the frame_done cycle coincides with the continuation
          // that is already starting, so it is not queued again.
          pending_nxt = 1'b1;
          if (pending) begin
            overrun_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge AUDIO_CLK or posedge reset_reg) begin
    if (reset_reg) begin
      state         <= IDLE;
      trig_dly      <= 1'b0;
      pending       <= 1'b0;
      overrun_r     <= 1'b0;
      slot          <= '0;
      run_r         <= 1'b0;
      frame_start_r <= 1'b0;
      frame_done_r  <= 1'b0;
      xxxx_zero_r   <= 1'b1;
    end else begin
      state         <= state_nxt;
      trig_dly      <= bus.trig;
      pending       <= pending_nxt;
      overrun_r     <= overrun_nxt;
      slot          <= slot_nxt;
      run_r         <= (state_nxt == RUN);
      frame_start_r <= frame_start_nxt;
      frame_done_r  <= frame_done_nxt;
      xxxx_zero_r   <= (slot_nxt == '0);
    end
  end

  assign bus.env_ce      = env_ce;
  assign bus.osc_ce      = env_ce & slot[0];
  assign bus.xxxx        = slot;
  assign bus.xxxx_zero   = xxxx_zero_r;
  assign bus.run         = run_r;
  assign bus.frame_start = frame_start_r;
  assign bus.frame_done  = frame_done_r;
  assign bus.overrun     = overrun_r;

endmodule
